// File: rtl/program_launcher.sv
// Push-button front end: synchronise, debounce and edge-detect each button, then
// launch the lowest-index pressed program for a fixed hold window and re-arm on release.
module program_launcher #(
  parameter int NUM_BTN         = 4,
  parameter int SEL_WIDTH       = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn,
  output logic [SEL_WIDTH-1:0] program_selector,
  output logic                 launch_pulse,
  output logic                 busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [HW-1:0]        r_hold_cnt;
  logic [HW-1:0]        w_hold_cnt_next;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [SEL_WIDTH-1:0] w_sel_next;
  logic                 r_launch;
  logic                 w_launch_next;

  logic [NUM_BTN-1:0]   w_db;
  logic [NUM_BTN-1:0]   w_rise;
  logic                 w_any_rise;
  logic [SEL_WIDTH-1:0] w_win_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic          r_s1;
      logic          r_s2;
      logic          r_db;
      logic          r_db_d;
      logic [CW-1:0] r_cnt;

      // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_db   <= 1'b0;
          r_db_d <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_s1   <= btn[gi];
          r_s2   <= r_s1;
          r_db_d <= r_db;
          if (r_s2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_db  <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      assign w_db[gi]   = r_db;
      assign w_rise[gi] = r_db & ~r_db_d;
    end
  endgenerate

  // Scan from the top down so the lowest set index overwrites the others.
  always_comb begin
    w_any_rise = |w_rise;
    w_win_sel  = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_win_sel = SEL_WIDTH'(i + 1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_sel      <= '0;
      r_launch   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_sel      <= w_sel_next;
      r_launch   <= w_launch_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_sel_next      = r_sel;
    w_launch_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_rise) begin
          w_state_next    = HOLD;
          w_sel_next      = w_win_sel;
          w_hold_cnt_next = HW'(HOLD_CYCLES - 1);
          w_launch_next   = 1'b1;
        end
      end
      HOLD: begin
        if (r_hold_cnt == '0) begin
          w_sel_next   = '0;
          w_state_next = WAIT_REL;
        end else begin
          w_hold_cnt_next = r_hold_cnt - HW'(1);
        end
      end
      WAIT_REL: begin
        // Rises seen here are intentionally discarded; every button must be released first.
        w_sel_next = '0;
        if (w_db == '0) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_sel_next   = '0;
      end
    endcase
  end

  assign program_selector = r_sel;
  assign launch_pulse     = r_launch;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_program_launcher.sv
// Directed bench for program_launcher with NUM_BTN=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
module tb_program_launcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn   = 4'b0000;
  logic [31:0] program_selector;
  logic        launch_pulse;
  logic        busy;

  int total = 0;
  int bad   = 0;

  program_launcher #(
    .NUM_BTN(4),
    .SEL_WIDTH(32),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn(btn),
    .program_selector(program_selector),
    .launch_pulse(launch_pulse),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = 4'b0000;
    step();
    step();
    total++;
    if (program_selector !== 32'd0 || launch_pulse !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: sel=%0d pulse=%b busy=%b, required 0/0/0",
               program_selector, launch_pulse, busy);
    end
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    logic [31:0] exp_sel;
    btn = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_sel = (k >= 7 && k <= 14) ? 32'd2 : 32'd0;
      total++;
      if (program_selector !== exp_sel) begin
        bad++;
        $display("FAIL t1_sel edge %0d: got %0d required %0d", k, program_selector, exp_sel);
      end
      total++;
      if (launch_pulse !== (k == 7)) begin
        bad++;
        $display("FAIL t1_pulse edge %0d: got %b required %b", k, launch_pulse, (k == 7));
      end
      total++;
      if (busy !== (k >= 7)) begin
        bad++;
        $display("FAIL t1_busy edge %0d: got %b required %b", k, busy, (k >= 7));
      end
    end
    btn = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (busy !== (k < 7) || program_selector !== 32'd0) begin
        bad++;
        $display("FAIL t1_release edge %0d: busy=%b sel=%0d required busy=%b sel=0",
                 k, busy, program_selector, (k < 7));
      end
    end
    $display("test_single_press done");
  endtask

  task automatic test_bounce();
    int n_launch;
    int launch_edge;
    n_launch    = 0;
    launch_edge = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e <= 10) btn[0] = (((e - 1) / 2) % 2 == 0);
      else         btn[0] = 1'b1;
      step();
      if (launch_pulse === 1'b1) begin
        n_launch++;
        launch_edge = e;
        total++;
        if (program_selector !== 32'd1) begin
          bad++;
          $display("FAIL t2_sel edge %0d: got %0d required 1", e, program_selector);
        end
      end
    end
    total++;
    if (n_launch != 1) begin
      bad++;
      $display("FAIL t2_launch_count: got %0d required 1", n_launch);
    end
    total++;
    if (launch_edge != 15) begin
      bad++;
      $display("FAIL t2_launch_edge: got %0d required 15", launch_edge);
    end
    btn = 4'b0000;
    wait_idle("t2");
    $display("test_bounce done");
  endtask

  task automatic test_short_pulse();
    for (int e = 1; e <= 20; e++) begin
      btn[0] = (e <= 3);
      step();
      total++;
      if (program_selector !== 32'd0 || busy !== 1'b0 || launch_pulse !== 1'b0) begin
        bad++;
        $display("FAIL t3_no_launch edge %0d: sel=%0d busy=%b pulse=%b required 0/0/0",
                 e, program_selector, busy, launch_pulse);
      end
    end
    btn = 4'b0000;
    $display("test_short_pulse done");
  endtask

  task automatic test_simultaneous();
    int n_launch;
    logic [31:0] exp_sel;
    n_launch = 0;
    btn = 4'b1100;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (launch_pulse === 1'b1) n_launch++;
      exp_sel = (e >= 7 && e <= 14) ? 32'd3 : 32'd0;
      total++;
      if (program_selector !== exp_sel) begin
        bad++;
        $display("FAIL t4_sel edge %0d: got %0d required %0d", e, program_selector, exp_sel);
      end
    end
    total++;
    if (n_launch != 1) begin
      bad++;
      $display("FAIL t4_launch_count: got %0d required 1", n_launch);
    end
    btn = 4'b0000;
    wait_idle("t4");
    $display("test_simultaneous done");
  endtask

  task automatic test_drop_during_hold();
    int n_launch;
    logic [31:0] exp_sel;
    n_launch = 0;
    btn = 4'b0001;
    for (int e = 1; e <= 40; e++) begin
      if (e == 10) btn[3] = 1'b1;
      if (e == 26) btn = 4'b0000;
      step();
      if (launch_pulse === 1'b1) n_launch++;
      exp_sel = (e >= 7 && e <= 14) ? 32'd1 : 32'd0;
      total++;
      if (program_selector !== exp_sel) begin
        bad++;
        $display("FAIL t5_sel edge %0d: got %0d required %0d", e, program_selector, exp_sel);
      end
    end
    total++;
    if (n_launch != 1) begin
      bad++;
      $display("FAIL t5_launch_count: got %0d required 1", n_launch);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL t5_busy_end: got %b required 0", busy);
    end
    $display("test_drop_during_hold done");
  endtask

  task automatic test_reset_mid_hold();
    logic [31:0] exp_sel;
    btn = 4'b0010;
    for (int e = 1; e <= 9; e++) step();
    total++;
    if (program_selector !== 32'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL t6_in_hold: sel=%0d busy=%b required 2/1", program_selector, busy);
    end
    btn   = 4'b0000;
    reset = 1'b1;
    #1;
    total++;
    if (program_selector !== 32'd0 || busy !== 1'b0 || launch_pulse !== 1'b0) begin
      bad++;
      $display("FAIL t6_async_reset: sel=%0d busy=%b pulse=%b required 0/0/0",
               program_selector, busy, launch_pulse);
    end
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      total++;
      if (program_selector !== 32'd0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL t6_post_reset edge %0d: sel=%0d busy=%b required 0/0",
                 e, program_selector, busy);
      end
    end
    btn = 4'b0100;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_sel = (e >= 7 && e <= 14) ? 32'd3 : 32'd0;
      total++;
      if (program_selector !== exp_sel || launch_pulse !== (e == 7)) begin
        bad++;
        $display("FAIL t6_relaunch edge %0d: sel=%0d pulse=%b required %0d/%b",
                 e, program_selector, launch_pulse, exp_sel, (e == 7));
      end
    end
    btn = 4'b0000;
    wait_idle("t6");
    $display("test_reset_mid_hold done");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_short_pulse();
    test_simultaneous();
    test_drop_during_hold();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
